// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, fetches words over req/gnt/rvalid, buffers them in a prefetch FIFO.
// Optional macro IF_FLUSH_CNT_EN adds flush_cnt_o, a count of instructions discarded by redirects.
module if_stage #(
    parameter int unsigned              WORD_WIDTH = 32,
    parameter logic [WORD_WIDTH-1:0]    BOOT_ADDR  = 32'h0000_0000,
    parameter int unsigned              FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  instr_req_o,
    output logic [WORD_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_gnt_i,
    input  logic                  instr_rvalid_i,
    input  logic [WORD_WIDTH-1:0] instr_rdata_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [WORD_WIDTH-1:0] instruction_o,
    output logic [WORD_WIDTH-1:0] program_count_o,
    input  logic [WORD_WIDTH-1:0] pc_branch_addr_i,
    input  logic                  pc_branch_ctrl_i
`ifdef IF_FLUSH_CNT_EN
    ,
    output logic [WORD_WIDTH-1:0] flush_cnt_o
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [WORD_WIDTH-1:0] NOP_INSTR = WORD_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_WAIT,
        ST_DROP
    } state_t;

    state_t                state_q;
    state_t                state_nxt;
    logic [WORD_WIDTH-1:0] fetch_addr;
    logic [WORD_WIDTH-1:0] req_pc;
    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [WORD_WIDTH-1:0] fifo_instr [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0] fifo_pc    [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0] hold_instr;
    logic [WORD_WIDTH-1:0] hold_pc;

    logic redirect;
    logic fifo_full;
    logic fifo_empty;
    logic req;
    logic grant;
    logic push;
    logic pop;

    assign redirect   = pc_branch_ctrl_i;
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);

    // Next state, request and push decisions; a redirect overrides everything this cycle
    always_comb begin
        state_nxt = state_q;
        req       = 1'b0;
        push      = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                req = !fifo_full && !redirect;
                if (req && instr_gnt_i) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (instr_rvalid_i) begin
                    state_nxt = ST_FETCH;
                    push      = !redirect;
                end else if (redirect) begin
                    state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                // A redirect here keeps dropping; the returning word still closes the transaction
                if (instr_rvalid_i) begin
                    state_nxt = ST_FETCH;
                end
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    assign grant = req && instr_gnt_i;
    assign pop   = instr_valid_o && instr_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            fetch_addr <= BOOT_ADDR;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            hold_instr <= NOP_INSTR;
            hold_pc    <= BOOT_ADDR;
        end else begin
            state_q <= state_nxt;
            if (redirect) begin
                fetch_addr <= pc_branch_addr_i & ~WORD_WIDTH'(3);
            end else if (grant) begin
                fetch_addr <= fetch_addr + WORD_WIDTH'(4);
            end
            if (redirect) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
            // Remember the head on display so the outputs hold it once the FIFO runs dry
            if (!fifo_empty) begin
                hold_instr <= fifo_instr[rd_ptr];
                hold_pc    <= fifo_pc[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            req_pc <= fetch_addr;
        end
        if (push) begin
            fifo_instr[wr_ptr] <= instr_rdata_i;
            fifo_pc[wr_ptr]    <= req_pc;
        end
    end

    assign instr_req_o     = req;
    assign instr_addr_o    = fetch_addr;
    assign instr_valid_o   = !fifo_empty && !redirect;
    assign instruction_o   = fifo_empty ? hold_instr : fifo_instr[rd_ptr];
    assign program_count_o = fifo_empty ? hold_pc    : fifo_pc[rd_ptr];

`ifdef IF_FLUSH_CNT_EN
    logic                  drop_resp;
    logic [WORD_WIDTH-1:0] flush_cnt;

    assign drop_resp = instr_rvalid_i &&
                       ((state_q == ST_DROP) || ((state_q == ST_WAIT) && redirect));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= '0;
        end else if (redirect || drop_resp) begin
            flush_cnt <= flush_cnt + (redirect ? WORD_WIDTH'(count) : '0) + WORD_WIDTH'(drop_resp);
        end
    end

    assign flush_cnt_o = flush_cnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a transaction-level model (expected instruction queue, epochs for
// in-flight fetches) is compared against the DUT every cycle, plus hand-computed literal checks.
module tb_if_stage;

    localparam int          DEPTH   = 2;
    localparam logic [31:0] BOOT    = 32'h0000_0000;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instruction_o;
    logic [31:0] program_count_o;
    logic [31:0] pc_branch_addr_i = '0;
    logic        pc_branch_ctrl_i = 1'b0;
`ifdef IF_FLUSH_CNT_EN
    logic [31:0] flush_cnt_o;
`endif

    always #5 clk = ~clk;

    if_stage #(
        .WORD_WIDTH (32),
        .BOOT_ADDR  (BOOT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .instr_req_o      (instr_req_o),
        .instr_addr_o     (instr_addr_o),
        .instr_gnt_i      (instr_gnt_i),
        .instr_rvalid_i   (instr_rvalid_i),
        .instr_rdata_i    (instr_rdata_i),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instruction_o    (instruction_o),
        .program_count_o  (program_count_o),
        .pc_branch_addr_i (pc_branch_addr_i),
        .pc_branch_ctrl_i (pc_branch_ctrl_i)
`ifdef IF_FLUSH_CNT_EN
        ,
        .flush_cnt_o      (flush_cnt_o)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    int          checks = 0;
    int          errors = 0;
    ent_t        q[$];
    logic [31:0] delivered_pc[$];
    logic [31:0] delivered_ins[$];
    bit          boot = 1'b1;
    bit          outst = 1'b0;
    int          epoch = 0;
    int          out_epoch = 0;
    logic [31:0] exp_addr = BOOT;
    logic [31:0] req_pc_m = BOOT;
    logic [31:0] last_pc = BOOT;
    logic [31:0] last_ins = NOP;
    logic [31:0] flush_m = '0;
    int          cyc = 0;
    int          first_req_cyc = -1;
    bit          auto_mem = 1'b0;
    bit          cap_g = 1'b0;
    logic [31:0] cap_a = '0;
    int          d0;
    logic [31:0] fb;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, then advance the model to the coming clock edge
    task automatic model_step();
        ent_t h;
        bit   redir;
        bit   ereq;
        bit   evld;
        if (!rst_n) begin
            chk("rst_req", {31'd0, instr_req_o}, 32'd0);
            chk("rst_addr", instr_addr_o, BOOT);
            chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
            chk("rst_instr", instruction_o, NOP);
            chk("rst_pc", program_count_o, BOOT);
`ifdef IF_FLUSH_CNT_EN
            chk("rst_flush", flush_cnt_o, 32'd0);
`endif
            q.delete();
            boot = 1'b1;
            outst = 1'b0;
            exp_addr = BOOT;
            last_pc = BOOT;
            last_ins = NOP;
            flush_m = '0;
            cyc = 0;
            first_req_cyc = -1;
            return;
        end
        redir = pc_branch_ctrl_i;
        ereq  = !boot && !redir && !outst && (q.size() < DEPTH);
        chk("req", {31'd0, instr_req_o}, {31'd0, ereq});
        if (ereq) chk("req_addr", instr_addr_o, exp_addr);
        evld = (q.size() != 0) && !redir;
        chk("valid", {31'd0, instr_valid_o}, {31'd0, evld});
        if (q.size() != 0) begin
            h = q[0];
            chk("head_pc", program_count_o, h.pc);
            chk("head_instr", instruction_o, h.ins);
            last_pc = h.pc;
            last_ins = h.ins;
        end else begin
            chk("hold_pc", program_count_o, last_pc);
            chk("hold_instr", instruction_o, last_ins);
        end
`ifdef IF_FLUSH_CNT_EN
        chk("flush_cnt", flush_cnt_o, flush_m);
`endif
        if (ereq && first_req_cyc < 0) first_req_cyc = cyc;
        if (redir) begin
            flush_m = flush_m + 32'(q.size()) + ((instr_rvalid_i && outst) ? 32'd1 : 32'd0);
            q.delete();
            exp_addr = pc_branch_addr_i & ~32'h3;
            epoch++;
            if (instr_rvalid_i) outst = 1'b0;
        end else begin
            if (evld && instr_ready_i) begin
                delivered_pc.push_back(q[0].pc);
                delivered_ins.push_back(q[0].ins);
                void'(q.pop_front());
            end
            if (instr_rvalid_i && outst) begin
                if (out_epoch == epoch) q.push_back('{pc: req_pc_m, ins: instr_rdata_i});
                else flush_m = flush_m + 32'd1;
                outst = 1'b0;
            end
            if (ereq && instr_gnt_i) begin
                outst = 1'b1;
                out_epoch = epoch;
                req_pc_m = exp_addr;
                exp_addr = exp_addr + 32'd4;
            end
        end
        boot = 1'b0;
        cyc++;
    endtask

    // One clock: compare at the falling edge, then drive memory response and defaults after the rising edge
    task automatic tick();
        @(negedge clk);
        model_step();
        cap_g = instr_req_o && instr_gnt_i && rst_n;
        cap_a = instr_addr_o;
        @(posedge clk);
        #1;
        pc_branch_ctrl_i = 1'b0;
        if (auto_mem) begin
            instr_rvalid_i = cap_g;
            instr_rdata_i  = cap_g ? memfn(cap_a) : 32'd0;
        end else begin
            instr_rvalid_i = 1'b0;
        end
    endtask

    task automatic drain();
        instr_gnt_i = 1'b0;
        tick();
        tick();
        auto_mem = 1'b0;
        instr_ready_i = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;

        // Streaming fetch from reset
        auto_mem = 1'b1;
        instr_gnt_i = 1'b1;
        instr_ready_i = 1'b1;
        d0 = delivered_pc.size();
        for (int i = 0; i < 40 && delivered_pc.size() < d0 + 3; i++) tick();
        chk("t1_delivered3", {31'd0, delivered_pc.size() >= d0 + 3}, 32'd1);
        chk("t1_first_req_cycle", 32'(first_req_cyc), 32'd1);
        if (delivered_pc.size() >= d0 + 3) begin
            chk("t1_pc0", delivered_pc[d0], 32'h0);
            chk("t1_pc1", delivered_pc[d0+1], 32'h4);
            chk("t1_pc2", delivered_pc[d0+2], 32'h8);
            chk("t1_ins0", delivered_ins[d0], 32'h1357_9BDF);
            chk("t1_ins1", delivered_ins[d0+1], 32'h1357_9BDB);
        end

        // Decode stalls: FIFO fills and requests stop; one pop reopens one request
        instr_ready_i = 1'b0;
        repeat (8) tick();
        #1;
        chk("t2_full_req", {31'd0, instr_req_o}, 32'd0);
        chk("t2_full_valid", {31'd0, instr_valid_o}, 32'd1);
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
        #1;
        chk("t2_refill_req", {31'd0, instr_req_o}, 32'd1);
        chk("t2_refill_addr", instr_addr_o, delivered_pc[delivered_pc.size()-1] + 32'd8);
        repeat (3) tick();

        // Redirect while waiting; late response must be dropped
        drain();
        instr_gnt_i = 1'b1;
        tick();
        instr_gnt_i = 1'b0;
        pc_branch_ctrl_i = 1'b1;
        pc_branch_addr_i = 32'h100;
        tick();
        tick();
        instr_rvalid_i = 1'b1;
        instr_rdata_i = 32'hDEAD_BEEF;
        tick();
        #1;
        chk("t3_req", {31'd0, instr_req_o}, 32'd1);
        chk("t3_addr", instr_addr_o, 32'h100);
        d0 = delivered_pc.size();
        auto_mem = 1'b1;
        instr_gnt_i = 1'b1;
        instr_ready_i = 1'b1;
        for (int i = 0; i < 40 && delivered_pc.size() < d0 + 1; i++) tick();
        chk("t3_delivered", {31'd0, delivered_pc.size() > d0}, 32'd1);
        if (delivered_pc.size() > d0) begin
            chk("t3_pc", delivered_pc[d0], 32'h100);
            chk("t3_ins", delivered_ins[d0], 32'h1357_9ADF);
        end

        // Redirect coinciding with a response while one entry is buffered
        drain();
        instr_ready_i = 1'b0;
        instr_gnt_i = 1'b1;
        tick();
        instr_gnt_i = 1'b0;
        instr_rvalid_i = 1'b1;
        instr_rdata_i = memfn(cap_a);
        tick();
        instr_gnt_i = 1'b1;
        tick();
        instr_gnt_i = 1'b0;
`ifdef IF_FLUSH_CNT_EN
        fb = flush_cnt_o;
`else
        fb = '0;
`endif
        instr_rvalid_i = 1'b1;
        instr_rdata_i = memfn(cap_a);
        pc_branch_ctrl_i = 1'b1;
        pc_branch_addr_i = 32'h203;
        #1;
        chk("t4_valid_forced", {31'd0, instr_valid_o}, 32'd0);
        tick();
        #1;
        chk("t4_empty", {31'd0, instr_valid_o}, 32'd0);
        chk("t4_req", {31'd0, instr_req_o}, 32'd1);
        chk("t4_addr", instr_addr_o, 32'h200);
`ifdef IF_FLUSH_CNT_EN
        chk("t4_flush_delta", flush_cnt_o - fb, 32'd2);
`endif

        // Address wrap at the top of the address space
        pc_branch_ctrl_i = 1'b1;
        pc_branch_addr_i = 32'hFFFF_FFFC;
        auto_mem = 1'b1;
        instr_gnt_i = 1'b1;
        instr_ready_i = 1'b1;
        d0 = delivered_pc.size();
        for (int i = 0; i < 40 && delivered_pc.size() < d0 + 2; i++) tick();
        chk("t5_delivered2", {31'd0, delivered_pc.size() >= d0 + 2}, 32'd1);
        if (delivered_pc.size() >= d0 + 2) begin
            chk("t5_pc_top", delivered_pc[d0], 32'hFFFF_FFFC);
            chk("t5_pc_wrap", delivered_pc[d0+1], 32'h0000_0000);
        end

        // Asynchronous reset while waiting, stray response after release
        drain();
        instr_gnt_i = 1'b1;
        tick();
        instr_gnt_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_req", {31'd0, instr_req_o}, 32'd0);
        chk("t6_addr", instr_addr_o, BOOT);
        chk("t6_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("t6_instr", instruction_o, NOP);
        chk("t6_pc", program_count_o, BOOT);
        tick();
        tick();
        rst_n = 1'b1;
        instr_rvalid_i = 1'b1;
        instr_rdata_i = 32'hBAD0_BAD0;
        auto_mem = 1'b1;
        instr_gnt_i = 1'b1;
        instr_ready_i = 1'b1;
        d0 = delivered_pc.size();
        for (int i = 0; i < 40 && delivered_pc.size() < d0 + 1; i++) tick();
        chk("t6_delivered", {31'd0, delivered_pc.size() > d0}, 32'd1);
        chk("t6_first_req_cycle", 32'(first_req_cyc), 32'd1);
        if (delivered_pc.size() > d0) begin
            chk("t6_pc", delivered_pc[d0], BOOT);
            chk("t6_ins", delivered_ins[d0], 32'h1357_9BDF);
        end
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
